// File: rtl/burst_mem_adapter_pkg.sv
// burst_mem_adapter_pkg: line/beat geometry and adapter state type shared by the memory path
package burst_mem_adapter_pkg;
  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS = 4;
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, DONE} state_t;
endpackage

// File: rtl/burst_mem_adapter.sv
// burst_mem_adapter: 256-bit line requests (umem_*) to 4x64-bit bursts (bmem_*), one umem_resp per line
module burst_mem_adapter
  import burst_mem_adapter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          umem_addr,
  input  logic                 umem_read,
  input  logic                 umem_write,
  input  logic [LINE_BITS-1:0] umem_wdata,
  output logic [LINE_BITS-1:0] umem_rdata,
  output logic                 umem_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);
  state_t state, state_n;
  logic [1:0] k;
  logic [31:0] addr;
  logic [LINE_BITS-1:0] wline, rbuf;
  logic hit, adv;
  assign hit = state == RD_DATA && bmem_rvalid && bmem_raddr == addr;
  assign adv = hit || (state == WR_DATA && bmem_ready);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = umem_write ? WR_DATA : umem_read ? RD_CMD : IDLE;
      RD_CMD: state_n = bmem_ready ? RD_DATA : RD_CMD;
      RD_DATA, WR_DATA: state_n = adv && k == 2'(BEATS - 1) ? DONE : state;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= 2'd0;
      addr <= '0;
      wline <= '0;
      rbuf <= '0;
      umem_rdata <= '0;
    end else begin
      if (state == IDLE && (umem_read || umem_write)) addr <= umem_addr & 32'hffff_ffe0;
      if (state == IDLE && umem_write) wline <= umem_wdata;
      k <= (state == IDLE || state == RD_CMD) ? 2'd0 : adv ? k + 2'd1 : k;
      if (hit) rbuf[int'(k) * BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
      // publish the line only on the last beat so umem_rdata stays stable during the burst
      if (hit && k == 2'(BEATS - 1)) umem_rdata <= {bmem_rdata, rbuf[LINE_BITS-BEAT_BITS-1:0]};
    end
  end
  assign bmem_read = state == RD_CMD;
  assign bmem_write = state == WR_DATA;
  assign bmem_addr = (bmem_read || bmem_write) ? addr : '0;
  assign bmem_wdata = bmem_write ? wline[int'(k) * BEAT_BITS +: BEAT_BITS] : '0;
  assign umem_resp = state == DONE;
endmodule

// File: doc/burst_mem_adapter.md
BURST_MEM_ADAPTER -- requirements
Module: burst_mem_adapter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports exactly as listed below.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- umem_addr  in  32  line address from arbiter
- umem_read  in  1  line read request; held until umem_resp
- umem_write  in  1  line write request; held until umem_resp
- umem_wdata  in  256  write line
- umem_rdata  out  256  assembled read line
- umem_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst address, 32-byte aligned
- bmem_read  out  1  burst read command
- bmem_write  out  1  burst write beat valid
- bmem_wdata  out  64  write beat
- bmem_ready  in  1  memory accepts a command or beat this cycle
- bmem_raddr  in  32  address tag of the returning beat
- bmem_rdata  in  64  read beat
- bmem_rvalid  in  1  read beat valid

Function
REQ-002 The block SHALL implement the states IDLE, RD_CMD, RD_DATA, WR_DATA and DONE.
REQ-003 In IDLE, when umem_write=1 the block SHALL latch umem_addr[31:5]/5'b0 and umem_wdata, then enter WR_DATA. Write has priority if umem_read and umem_write are both 1.
REQ-004 In IDLE, when umem_read=1 and umem_write=0, the block SHALL latch the aligned address and enter RD_CMD.
REQ-005 In RD_CMD, the block SHALL drive bmem_read=1 and bmem_addr=latched address. It SHALL stay in RD_CMD until a cycle with bmem_ready=1, then enter RD_DATA.
REQ-006 In RD_DATA, each cycle with bmem_rvalid=1 and bmem_raddr=latched address SHALL store bmem_rdata into line bits [64k+63:64k], where k is the 2-bit beat counter, and increment k.
REQ-007 Beats arriving outside RD_DATA, or with a mismatched bmem_raddr, SHALL be ignored.
REQ-008 After the 4th read beat, the block SHALL enter DONE. In DONE it SHALL assert umem_resp=1 for exactly one cycle, with umem_rdata equal to the full line.
REQ-009 In WR_DATA, the block SHALL drive bmem_write=1, bmem_addr=latched address and bmem_wdata=latched line beat k.
- k advances only on bmem_ready=1; bmem_ready=0 holds the beat unchanged.
- After beat 3 is accepted, the block enters DONE.
REQ-010 DONE SHALL always return to IDLE on the next cycle. A request still asserted in that cycle SHALL NOT be accepted until IDLE.
REQ-011 Minimum latency with bmem_ready always 1:
- write: umem_resp 5 cycles after acceptance;
- read: umem_resp 1 cycle after the 4th valid beat.
REQ-012 umem_rdata SHALL hold its value until the next read completes. It SHALL NOT change during writes.
REQ-013 bmem_read and bmem_write SHALL never both be 1. Both SHALL be 0 in IDLE and DONE.
REQ-014 Upstream changes to umem_addr or umem_wdata after acceptance SHALL have no effect on the transaction in progress.
REQ-015 Beat counter arithmetic SHALL be modulo 4. The counter SHALL be cleared on every entry to RD_DATA or WR_DATA.

Reset
REQ-016 On rst=1, the block SHALL set state=IDLE, k=0, umem_resp=0, umem_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0 and bmem_wdata=0.
REQ-017 Reset mid-burst SHALL abandon the transaction with no umem_resp. Later stray beats SHALL be ignored per REQ-007.

Structure
REQ-018 The state enum and the constants LINE_BITS=256, BEAT_BITS=64 and BEATS=4 SHALL live in the shared memory package.
REQ-019 The block SHALL be a single module with no sub-modules. Line assembly SHALL be an indexed register write, not a shifter.

Verification
REQ-020 Read with ready=1: umem_addr=0x1234_5678. Expect bmem_addr=0x1234_5660 for 1 cycle. After beats 0x11..,0x22..,0x33..,0x44.. with raddr=0x1234_5660, expect one umem_resp with rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-021 Write with ready toggling 1,0,1,1,0,1: expect beats 0-3 each presented until accepted, wdata unchanged while ready=0, and umem_resp one cycle after beat 3 is accepted.
REQ-022 umem_read and umem_write both 1: expect a write burst and no bmem_read.
REQ-023 Stray rvalid in IDLE, plus a mismatched raddr during RD_DATA: expect umem_rdata unchanged and the beat count unaffected.
REQ-024 rst asserted after beat 2 of a read: expect IDLE next cycle, all outputs 0, and no umem_resp. A new read then completes normally.
REQ-025 umem_read held high through DONE: expect exactly one umem_resp and no second burst started before IDLE.
